instruction_fetch_stage: RTL and testbench

Front end of the five-stage pipelined MIPS processor: holds the program counter, presents it to instruction memory, and latches the fetched word into the IF/ID pipeline register. It sits directly upstream of decode. It takes stall and flush from the hazard unit and a taken branch/jump redirect from the branch-resolution stage. Its PC and latched instruction feed the processor-level `PCInstruction` debug output observed by the top-level bench.

---
 rtl/instruction_fetch_stage.sv | 54 +++++
 tb/tb_instruction_fetch_stage.sv | 107 ++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC register, instruction memory address, and IF/ID pipeline register
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] IMemData,
  output logic [31:0] IMemAddr,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] FetchCount,
  output logic        Misaligned
);
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, count_q, count_d, pc_plus4;
  logic        valid_q, valid_d, mis_q, mis_d, load;
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    load     = !Flush && !Stall;
    pc_d     = PCSrc ? {PCTarget[31:2], 2'b00} : Stall ? pc_q : pc_plus4;
    instr_d  = Flush ? 32'd0 : Stall ? instr_q : IMemData;
    pc4_d    = Flush ? 32'd0 : Stall ? pc4_q : pc_plus4;
    valid_d  = Flush ? 1'b0 : Stall ? valid_q : 1'b1;
    count_d  = count_q + 32'(load);
    mis_d    = mis_q | (PCSrc && |PCTarget[1:0]);
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
      mis_q   <= mis_d;
    end
  end
  assign IMemAddr         = pc_q;
  assign IFID_Instruction = instr_q;
  assign IFID_PCPlus4     = pc4_q;
  assign IFID_Valid       = valid_q;
  assign FetchCount       = count_q;
  assign Misaligned       = mis_q;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed checks of fetch, stall, flush, redirect, wrap and reset
module tb_instruction_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, stall, flush, pcsrc, rst1;
  logic        zero = 1'b0;
  logic [31:0] target, zero32 = 32'd0;
  logic [31:0] addr0, instr0, pc40, cnt0, data0;
  logic [31:0] addr1, instr1, pc41, cnt1, data1;
  logic        valid0, mis0, valid1, mis1;
  int          cmp = 0, errs = 0;
  always #5 clk = ~clk;
  assign data0 = addr0 ^ 32'h1000_0000;
  assign data1 = addr1 ^ 32'h1000_0000;
  instruction_fetch_stage dut0 (
    .Clk(clk), .Rst(rst), .Stall(stall), .Flush(flush), .PCSrc(pcsrc), .PCTarget(target),
    .IMemData(data0), .IMemAddr(addr0), .IFID_Instruction(instr0), .IFID_PCPlus4(pc40),
    .IFID_Valid(valid0), .FetchCount(cnt0), .Misaligned(mis0)
  );
  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .Clk(clk), .Rst(rst1), .Stall(zero), .Flush(zero), .PCSrc(zero), .PCTarget(zero32),
    .IMemData(data1), .IMemAddr(addr1), .IFID_Instruction(instr1), .IFID_PCPlus4(pc41),
    .IFID_Valid(valid1), .FetchCount(cnt1), .Misaligned(mis1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk0(input string tag, input logic [31:0] a, input logic [31:0] i,
                      input logic [31:0] p, input logic v, input logic [31:0] c, input logic m);
    chk({tag, ".addr"}, addr0, a);
    chk({tag, ".instr"}, instr0, i);
    chk({tag, ".pc4"}, pc40, p);
    chk({tag, ".valid"}, 32'(valid0), 32'(v));
    chk({tag, ".count"}, cnt0, c);
    chk({tag, ".mis"}, 32'(mis0), 32'(m));
  endtask
  initial begin
    rst = 1; rst1 = 1; stall = 0; flush = 0; pcsrc = 0; target = 0;
    pcsrc = 1; target = 32'h0000_0043; flush = 0; stall = 1;
    step();
    chk0("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);
    chk("w_reset.addr", addr1, 32'hFFFF_FFF8);
    chk("w_reset.valid", 32'(valid1), 32'd0);
    rst = 0; rst1 = 0; pcsrc = 0; target = 0; stall = 0;
    step();
    chk0("f0", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'd1, 1'b0);
    chk("w1.addr", addr1, 32'hFFFF_FFFC);
    chk("w1.instr", instr1, 32'hEFFF_FFF8);
    chk("w1.pc4", pc41, 32'hFFFF_FFFC);
    step();
    chk0("f1", 32'h8, 32'h1000_0004, 32'h8, 1'b1, 32'd2, 1'b0);
    chk("w2.addr", addr1, 32'h0);
    chk("w2.instr", instr1, 32'hEFFF_FFFC);
    chk("w2.pc4", pc41, 32'h0);
    chk("w2.valid", 32'(valid1), 32'd1);
    stall = 1;
    step();
    chk0("stall1", 32'h8, 32'h1000_0004, 32'h8, 1'b1, 32'd2, 1'b0);
    chk("w3.addr", addr1, 32'h4);
    chk("w3.count", cnt1, 32'd3);
    step();
    chk0("stall2", 32'h8, 32'h1000_0004, 32'h8, 1'b1, 32'd2, 1'b0);
    stall = 0;
    step();
    chk0("resume", 32'hC, 32'h1000_0008, 32'hC, 1'b1, 32'd3, 1'b0);
    pcsrc = 1; target = 32'h40; flush = 1;
    step();
    chk0("redir_flush", 32'h40, 32'h0, 32'h0, 1'b0, 32'd3, 1'b0);
    pcsrc = 0; flush = 0;
    step();
    chk0("target_fetch", 32'h44, 32'h1000_0040, 32'h44, 1'b1, 32'd4, 1'b0);
    pcsrc = 1; target = 32'h80;
    step();
    chk0("redir_noflush", 32'h80, 32'h1000_0044, 32'h48, 1'b1, 32'd5, 1'b0);
    pcsrc = 1; target = 32'h103; stall = 1; flush = 1;
    step();
    chk0("all3", 32'h100, 32'h0, 32'h0, 1'b0, 32'd5, 1'b1);
    pcsrc = 0; stall = 0; flush = 0;
    step();
    chk0("after_all3", 32'h104, 32'h1000_0100, 32'h104, 1'b1, 32'd6, 1'b1);
    stall = 1; flush = 1;
    step();
    chk0("stall_flush", 32'h104, 32'h0, 32'h0, 1'b0, 32'd6, 1'b1);
    stall = 0; flush = 0;
    step();
    chk0("post_sf", 32'h108, 32'h1000_0104, 32'h108, 1'b1, 32'd7, 1'b1);
    rst = 1; rst1 = 1;
    step();
    chk0("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);
    chk("w_rst.addr", addr1, 32'hFFFF_FFF8);
    chk("w_rst.valid", 32'(valid1), 32'd0);
    chk("w_rst.count", cnt1, 32'd0);
    chk("w_rst.instr", instr1, 32'd0);
    rst = 0; rst1 = 0;
    step();
    chk0("refetch", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'd1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
